// File: rtl/piezo_txrx_arbiter.sv
// rtl/piezo_txrx_arbiter.sv - two-requester piezo TX/RX arbiter with guard intervals
//
// Purpose: shares one piezo transducer between two transmit requesters
// (bit0 PTP interface, bit1 RTC). In idle the receiver is enabled; a request
// wins round-robin arbitration, waits out a guard interval with both enables
// off, drives the piezo, then waits out a second guard interval before the
// receiver is re-enabled.
//
// Optional feature: define PIEZO_ARB_WATCHDOG_EN to compile in a TX watchdog
// that forces the transmitter off after TX_MAX_CYCLES cycles in TX.
//
// Ports:
//   iCLK             system clock
//   iRESETn          synchronous active-low reset
//   iREQ[1:0]        transmit request per requester
//   iDRIVE[1:0]      piezo drive waveform per requester
//   oGNT[1:0]        one-hot grant (registered)
//   oPIEZO           drive of the granted requester, only while in TX
//   oENABLE_PIEZO    transmitter enable (registered)
//   oENABLE_PIEZO_IN receiver enable (registered)
//   oBUSY            high in every state except RX
//   oTIMEOUT         one-cycle pulse when the watchdog fires

module piezo_txrx_arbiter #(
   parameter int DEAD_CYCLES   = 4,
   parameter int TX_MAX_CYCLES = 4096
) (
   input  logic       iCLK,
   input  logic       iRESETn,
   input  logic [1:0] iREQ,
   input  logic [1:0] iDRIVE,
   output logic [1:0] oGNT,
   output logic       oPIEZO,
   output logic       oENABLE_PIEZO,
   output logic       oENABLE_PIEZO_IN,
   output logic       oBUSY,
   output logic       oTIMEOUT
);

   typedef enum logic [1:0] {
      RX      = 2'd0,
      DEAD_TX = 2'd1,
      TX      = 2'd2,
      DEAD_RX = 2'd3
   } state_t;

   localparam logic [7:0] GuardLast = 8'(DEAD_CYCLES - 1);

   if (DEAD_CYCLES < 1 || DEAD_CYCLES > 255 ||
       TX_MAX_CYCLES < 1 || TX_MAX_CYCLES > 65535) begin : gParamCheck
      $error("piezo_txrx_arbiter: parameter out of legal range");
   end

   state_t     state;
   logic [7:0] guardCnt;
   logic       winner;   // latched index of the granted requester
   logic       rrPri;    // requester that wins when both request
   logic       pick;
   logic       txExpire;

`ifdef PIEZO_ARB_WATCHDOG_EN
   localparam logic [15:0] TxLast = 16'(TX_MAX_CYCLES - 1);
   logic [15:0] txCnt;
   logic        timeoutQ;

   assign txExpire = (txCnt == TxLast);
   assign oTIMEOUT = timeoutQ;
`else
   assign txExpire = 1'b0;
   assign oTIMEOUT = 1'b0;
`endif

   always_comb begin
      pick = 1'b0;
      if (iREQ == 2'b11) begin
         pick = rrPri;
      end else begin
         pick = iREQ[1];
      end
   end

   assign oBUSY  = (state != RX);
   assign oPIEZO = (state == TX) ? iDRIVE[winner] : 1'b0;

   always_ff @(posedge iCLK) begin
      if (!iRESETn) begin
         state            <= RX;
         oGNT             <= 2'b00;
         oENABLE_PIEZO    <= 1'b0;
         oENABLE_PIEZO_IN <= 1'b1;
         guardCnt         <= 8'd0;
         winner           <= 1'b0;
         rrPri            <= 1'b0;
`ifdef PIEZO_ARB_WATCHDOG_EN
         txCnt            <= 16'd0;
         timeoutQ         <= 1'b0;
`endif
      end else begin
`ifdef PIEZO_ARB_WATCHDOG_EN
         timeoutQ <= 1'b0;
`endif
         case (state)
            RX: begin
               if (iREQ != 2'b00) begin
                  state            <= DEAD_TX;
                  winner           <= pick;
                  rrPri            <= ~pick;
                  oGNT             <= pick ? 2'b10 : 2'b01;
                  oENABLE_PIEZO_IN <= 1'b0;
                  guardCnt         <= 8'd0;
               end
            end
            DEAD_TX: begin
               // A withdrawn request aborts straight to the RX guard, even on
               // the last guard cycle, so TX is never entered.
               if (!iREQ[winner]) begin
                  state    <= DEAD_RX;
                  oGNT     <= 2'b00;
                  guardCnt <= 8'd0;
               end else if (guardCnt == GuardLast) begin
                  state         <= TX;
                  oENABLE_PIEZO <= 1'b1;
                  guardCnt      <= 8'd0;
`ifdef PIEZO_ARB_WATCHDOG_EN
                  txCnt         <= 16'd0;
`endif
               end else begin
                  guardCnt <= guardCnt + 8'd1;
               end
            end
            TX: begin
               if (!iREQ[winner] || txExpire) begin
                  state         <= DEAD_RX;
                  oGNT          <= 2'b00;
                  oENABLE_PIEZO <= 1'b0;
                  guardCnt      <= 8'd0;
`ifdef PIEZO_ARB_WATCHDOG_EN
                  timeoutQ      <= txExpire;
                  // A timed-out requester yields the next contested grant.
                  if (txExpire) begin
                     rrPri <= ~winner;
                  end
`endif
               end else begin
`ifdef PIEZO_ARB_WATCHDOG_EN
                  txCnt <= txCnt + 16'd1;
`endif
               end
            end
            DEAD_RX: begin
               if (guardCnt == GuardLast) begin
                  state            <= RX;
                  oENABLE_PIEZO_IN <= 1'b1;
                  guardCnt         <= 8'd0;
               end else begin
                  guardCnt <= guardCnt + 8'd1;
               end
            end
            default: begin
               state <= RX;
            end
         endcase
      end
   end

endmodule
